// File: rtl/sample_capture.sv
`default_nettype none
// ============================================================================
// Module      : sample_capture
// Description : Triggered ADC sample capture buffer. Keeps PRE_SAMPLES samples
//               ahead of a level-crossing trigger and fills the remainder of a
//               DEPTH-deep circular buffer afterwards. Readback is
//               time-ordered: rd_addr 0 is the oldest captured sample.
//               Optional macro AUTO_TRIG_EN adds a forced trigger after
//               AUTO_TIMEOUT valid samples spent waiting for a real trigger.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_capture #(
   parameter int DEPTH        = 512,
   parameter int PRE_SAMPLES  = 64,
   parameter int AUTO_TIMEOUT = 4095
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sample_valid,
   input  logic [11:0]              sample_data,
   input  logic [11:0]              trig_level,
   input  logic                     trig_slope,
   input  logic                     arm,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [11:0]              rd_data,
   output logic                     busy,
   output logic                     capture_done,
   output logic                     trig_forced
);

   localparam int AW = $clog2(DEPTH);
   // Last pre-trigger write index and last post-trigger write index
   localparam logic [AW-1:0] c_PRE_LAST  = AW'(PRE_SAMPLES - 1);
   localparam logic [AW-1:0] c_POST_LAST = AW'(DEPTH - PRE_SAMPLES - 2);
   localparam logic [AW-1:0] c_PRE_OFS   = AW'(PRE_SAMPLES);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PRE       = 3'd1,
      WAIT_TRIG = 3'd2,
      POST      = 3'd3,
      DONE      = 3'd4
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [11:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_start_ptr;
   logic [AW-1:0] r_pre_cnt;
   logic [AW-1:0] r_post_cnt;
   logic [11:0]   r_prev;
   logic          r_prev_valid;
   logic [AW-1:0] w_rd_idx;
   logic          w_wr;
   logic          w_arm_ok;
   logic          w_real_trig;
   logic          w_force_trig;
   logic          w_trig;

   assign w_wr     = sample_valid && (r_state == PRE || r_state == WAIT_TRIG || r_state == POST);
   assign w_arm_ok = arm && (r_state == IDLE || r_state == DONE);
   // Buffer depth is a power of two, so the address sum wraps naturally
   assign w_rd_idx = r_start_ptr + rd_addr;

   // Level crossing against the previous stored sample, threshold and slope taken live
   assign w_real_trig = (r_state == WAIT_TRIG) && w_wr && r_prev_valid &&
                        (trig_slope ? (r_prev > trig_level && sample_data <= trig_level)
                                    : (r_prev < trig_level && sample_data >= trig_level));

`ifdef AUTO_TRIG_EN
   localparam int TW = $clog2(AUTO_TIMEOUT + 1);
   localparam logic [TW-1:0] c_TO_LAST = TW'(AUTO_TIMEOUT - 1);

   logic [TW-1:0] r_tcnt;
   logic          r_forced;

   // The AUTO_TIMEOUT-th waiting sample becomes the trigger if nothing real fired
   assign w_force_trig = (r_state == WAIT_TRIG) && w_wr && (r_tcnt == c_TO_LAST);
   assign trig_forced  = r_forced;

   // Waiting-sample counter and sticky forced-trigger flag, both cleared by arm
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tcnt   <= '0;
         r_forced <= 1'b0;
      end else if (w_arm_ok) begin
         r_tcnt   <= '0;
         r_forced <= 1'b0;
      end else begin
         if (r_state == WAIT_TRIG && w_wr)
            r_tcnt <= r_tcnt + TW'(1);
         if (w_force_trig && !w_real_trig)
            r_forced <= 1'b1;
      end
   end
`else
   logic [31:0] w_unused_timeout;

   assign w_unused_timeout = AUTO_TIMEOUT;
   assign w_force_trig     = 1'b0;
   assign trig_forced      = 1'b0;
`endif

   assign w_trig = w_real_trig || w_force_trig;

   // Next-state and status outputs
   always_comb begin
      w_state_nxt  = r_state;
      busy         = 1'b0;
      capture_done = 1'b0;
      case (r_state)
         IDLE: begin
            if (arm) w_state_nxt = PRE;
         end
         PRE: begin
            busy = 1'b1;
            if (w_wr && r_pre_cnt == c_PRE_LAST) w_state_nxt = WAIT_TRIG;
         end
         WAIT_TRIG: begin
            busy = 1'b1;
            if (w_trig) w_state_nxt = POST;
         end
         POST: begin
            busy = 1'b1;
            if (w_wr && r_post_cnt == c_POST_LAST) w_state_nxt = DONE;
         end
         DONE: begin
            capture_done = 1'b1;
            if (arm) w_state_nxt = PRE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State register, pointers, counters and registered readback
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_wptr       <= '0;
         r_start_ptr  <= '0;
         r_pre_cnt    <= '0;
         r_post_cnt   <= '0;
         r_prev       <= '0;
         r_prev_valid <= 1'b0;
         rd_data      <= '0;
      end else begin
         r_state <= w_state_nxt;
         rd_data <= r_mem[w_rd_idx];
         if (w_arm_ok) begin
            r_wptr       <= '0;
            r_pre_cnt    <= '0;
            r_post_cnt   <= '0;
            r_prev_valid <= 1'b0;
         end else if (w_wr) begin
            r_wptr       <= r_wptr + AW'(1);
            r_prev       <= sample_data;
            r_prev_valid <= 1'b1;
            if (r_state == PRE)  r_pre_cnt  <= r_pre_cnt + AW'(1);
            if (r_state == POST) r_post_cnt <= r_post_cnt + AW'(1);
            // Oldest kept sample sits PRE_SAMPLES slots behind the trigger sample
            if (w_trig) r_start_ptr <= r_wptr - c_PRE_OFS;
         end
      end
   end

   // Sample storage; contents survive reset
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr] <= sample_data;
   end

endmodule
`default_nettype wire
